// File: rtl/rggen_register_arbiter_if.sv
// Host and register-bus signals of the two-host register arbiter.
// slave: arbiter side; master: the hosts plus the register block around it.
interface rggen_register_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                     i_h0_request;
  logic [ADDRESS_WIDTH-1:0] i_h0_address;
  logic                     i_h0_write;
  logic [DATA_WIDTH-1:0]    i_h0_write_data;
  logic                     o_h0_done;
  logic [DATA_WIDTH-1:0]    o_h0_read_data;
  logic [1:0]               o_h0_status;

  logic                     i_h1_request;
  logic [ADDRESS_WIDTH-1:0] i_h1_address;
  logic                     i_h1_write;
  logic [DATA_WIDTH-1:0]    i_h1_write_data;
  logic                     o_h1_done;
  logic [DATA_WIDTH-1:0]    o_h1_read_data;
  logic [1:0]               o_h1_status;

  logic                     o_request;
  logic [ADDRESS_WIDTH-1:0] o_address;
  logic                     o_write;
  logic [DATA_WIDTH-1:0]    o_write_data;
  logic                     i_select;
  logic                     i_ready;
  logic [DATA_WIDTH-1:0]    i_read_data;

  modport slave (
    input  i_h0_request, i_h0_address, i_h0_write, i_h0_write_data,
    output o_h0_done, o_h0_read_data, o_h0_status,
    input  i_h1_request, i_h1_address, i_h1_write, i_h1_write_data,
    output o_h1_done, o_h1_read_data, o_h1_status,
    output o_request, o_address, o_write, o_write_data,
    input  i_select, i_ready, i_read_data
  );

  modport master (
    output i_h0_request, i_h0_address, i_h0_write, i_h0_write_data,
    input  o_h0_done, o_h0_read_data, o_h0_status,
    output i_h1_request, i_h1_address, i_h1_write, i_h1_write_data,
    input  o_h1_done, o_h1_read_data, o_h1_status,
    input  o_request, o_address, o_write, o_write_data,
    output i_select, i_ready, i_read_data
  );
endinterface

// File: rtl/rggen_register_arbiter.sv
// Round-robin arbiter letting two hosts share one register bus, with decode-error
// and wait-timeout reporting. TIMEOUT must lie in 1..255 (8-bit wait counter).
module rggen_register_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 15
)(
  input logic                   i_clk,
  input logic                   i_rst,
  rggen_register_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  localparam logic [7:0] TIMEOUT_COUNT = 8'(TIMEOUT);

  state_t                   state_reg, state_next;
  logic                     grant_reg, grant_next;
  logic                     priority_reg;
  logic [7:0]               wait_count_reg, wait_count_next;
  logic [ADDRESS_WIDTH-1:0] address_reg;
  logic                     write_reg;
  logic [DATA_WIDTH-1:0]    write_data_reg;
  logic                     done_reg [2];
  logic [DATA_WIDTH-1:0]    read_data_reg [2];
  logic [1:0]               status_reg [2];

  logic [1:0]               request;
  logic                     finish;
  logic [DATA_WIDTH-1:0]    response_data;
  logic [1:0]               response_status;

  assign request = {bus.i_h1_request, bus.i_h0_request};

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    wait_count_next = wait_count_reg;
    finish          = 1'b0;
    response_data   = '0;
    response_status = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|request) begin
          // On a tie the pointer decides; otherwise the lone requester wins.
          grant_next      = (&request) ? priority_reg : request[1];
          wait_count_next = '0;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.i_select) begin
          finish          = 1'b1;
          response_status = 2'b10;
        end else if (bus.i_ready) begin
          finish          = 1'b1;
          response_data   = write_reg ? '0 : bus.i_read_data;
        end else begin
          wait_count_next = wait_count_reg + 8'd1;
          if (wait_count_next == TIMEOUT_COUNT) begin
            finish          = 1'b1;
            response_status = 2'b11;
          end
        end
        if (finish) begin
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      priority_reg   <= 1'b0;
      wait_count_reg <= '0;
      address_reg    <= '0;
      write_reg      <= 1'b0;
      write_data_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      wait_count_reg <= wait_count_next;
      if (state_reg == IDLE && (|request)) begin
        address_reg    <= grant_next ? bus.i_h1_address    : bus.i_h0_address;
        write_reg      <= grant_next ? bus.i_h1_write      : bus.i_h0_write;
        write_data_reg <= grant_next ? bus.i_h1_write_data : bus.i_h0_write_data;
      end
      // The host just served drops to lowest priority.
      if (state_reg == RESPOND) begin
        priority_reg <= ~grant_reg;
      end
    end
  end

  // Done pulses and responses are launched on the edge entering RESPOND.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        done_reg[i]      <= 1'b0;
        read_data_reg[i] <= '0;
        status_reg[i]    <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        done_reg[i] <= finish && (grant_reg == 1'(i));
        if (finish && (grant_reg == 1'(i))) begin
          read_data_reg[i] <= response_data;
          status_reg[i]    <= response_status;
        end
      end
    end
  end

  assign bus.o_request      = (state_reg == ACCESS);
  assign bus.o_address      = address_reg;
  assign bus.o_write        = write_reg;
  assign bus.o_write_data   = write_data_reg;
  assign bus.o_h0_done      = done_reg[0];
  assign bus.o_h0_read_data = read_data_reg[0];
  assign bus.o_h0_status    = status_reg[0];
  assign bus.o_h1_done      = done_reg[1];
  assign bus.o_h1_read_data = read_data_reg[1];
  assign bus.o_h1_status    = status_reg[1];
endmodule

// File: tb/tb_rggen_register_arbiter.sv
// Randomized bench for the two-host register arbiter: a transaction-level model
// predicts each cycle's outputs from the planned register response; a negedge process compares.
module tb_rggen_register_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rggen_register_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rggen_register_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // host-side model
  bit            pend   [2];
  logic [AW-1:0] h_addr [2];
  bit            h_wr   [2];
  logic [DW-1:0] h_wd   [2];
  int            prio;

  // expected outputs for the current cycle
  bit            chk_en = 1'b0;
  logic          exp_req;
  logic [AW-1:0] exp_addr;
  logic          exp_wr;
  logic [DW-1:0] exp_wd;
  logic          exp_done [2];
  logic [DW-1:0] exp_rd   [2];
  logic [1:0]    exp_st   [2];

  // observed from the DUT, used by the literal checks
  int run_len   = 0;
  int last_len  = 0;
  int last_done = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hosts();
    bus.i_h0_request    = pend[0];
    bus.i_h0_address    = h_addr[0];
    bus.i_h0_write      = h_wr[0];
    bus.i_h0_write_data = h_wd[0];
    bus.i_h1_request    = pend[1];
    bus.i_h1_address    = h_addr[1];
    bus.i_h1_write      = h_wr[1];
    bus.i_h1_write_data = h_wd[1];
  endtask

  task automatic new_request(input int h);
    pend[h]   = 1'b1;
    h_addr[h] = AW'($urandom);
    h_wr[h]   = 1'($urandom_range(0, 1));
    h_wd[h]   = DW'($urandom);
    drive_hosts();
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic run_access(input bit sel, input int ready_at, input logic [DW-1:0] rdata,
                            input bit allow_late, output int g);
    int            len;
    bit            hit;
    logic [1:0]    st;
    logic [DW-1:0] rd;
    g   = (pend[0] && pend[1]) ? prio : (pend[0] ? 0 : 1);
    hit = sel && ready_at >= 1 && ready_at <= TO;
    len = !sel ? 1 : (hit ? ready_at : TO);
    st  = !sel ? 2'b10 : (hit ? 2'b00 : 2'b11);
    rd  = (hit && !h_wr[g]) ? rdata : '0;
    for (int a = 1; a <= len; a++) begin
      next_cycle();
      exp_req  = 1'b1;
      exp_addr = h_addr[g];
      exp_wr   = h_wr[g];
      exp_wd   = h_wd[g];
      bus.i_select    = sel;
      bus.i_ready     = sel ? (a == ready_at) : 1'($urandom_range(0, 1));
      bus.i_read_data = (a == ready_at) ? rdata : DW'($urandom);
      if (allow_late && a == 1 && !pend[1-g] && $urandom_range(0, 2) == 0) begin
        new_request(1 - g);
      end
    end
    next_cycle();
    exp_req     = 1'b0;
    exp_done[g] = 1'b1;
    exp_rd[g]   = rd;
    exp_st[g]   = st;
    bus.i_select    = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_read_data = DW'($urandom);
    next_cycle();
    exp_done[g] = 1'b0;
    pend[g]     = 1'b0;
    prio        = 1 - g;
    drive_hosts();
    $display("access host=%0d addr=%h write=%0d select=%0d ready_at=%0d status=%b data=%h",
             g, h_addr[g], h_wr[g], sel, ready_at, st, rd);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
      end else begin
        if (bus.o_request) run_len++;
        if (bus.o_h0_done || bus.o_h1_done) begin
          last_len  = run_len;
          run_len   = 0;
          last_done = bus.o_h1_done ? 1 : 0;
        end
      end
      if (chk_en) begin
        check("o_request", bus.o_request, exp_req);
        if (exp_req) begin
          check("o_address", bus.o_address, exp_addr);
          check("o_write", bus.o_write, exp_wr);
          check("o_write_data", bus.o_write_data, exp_wd);
        end
        check("h0_done", bus.o_h0_done, exp_done[0]);
        check("h1_done", bus.o_h1_done, exp_done[1]);
        check("h0_read_data", bus.o_h0_read_data, exp_rd[0]);
        check("h1_read_data", bus.o_h1_read_data, exp_rd[1]);
        check("h0_status", bus.o_h0_status, exp_st[0]);
        check("h1_status", bus.o_h1_status, exp_st[1]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int want_seq [4];
    int seq      [4];
    bit sel;
    int ra;
    want_seq = '{0, 1, 0, 1};
    for (int h = 0; h < 2; h++) begin
      pend[h] = 1'b0; h_addr[h] = '0; h_wr[h] = 1'b0; h_wd[h] = '0;
      exp_done[h] = 1'b0; exp_rd[h] = '0; exp_st[h] = 2'b00;
    end
    prio = 0;
    exp_req = 1'b0; exp_addr = '0; exp_wr = 1'b0; exp_wd = '0;
    drive_hosts();
    bus.i_select = 1'b0; bus.i_ready = 1'b0; bus.i_read_data = '0;

    // reset state, checked by the compare process while reset is held
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    rst = 1'b0;

    // h0 read with immediate ready
    pend[0] = 1'b1; h_addr[0] = 16'h0010; h_wr[0] = 1'b0; h_wd[0] = '0;
    drive_hosts();
    run_access(1'b1, 1, 32'hDEADBEEF, 1'b0, g);
    check("ready_now_data", bus.o_h0_read_data, 32'hDEADBEEF);
    check("ready_now_status", bus.o_h0_status, 2'b00);
    check("ready_now_len", last_len, 1);

    // timeout: ready never comes
    pend[0] = 1'b1; h_addr[0] = 16'h0020; h_wr[0] = 1'b0;
    drive_hosts();
    run_access(1'b1, 0, 32'h11111111, 1'b0, g);
    check("timeout_status", bus.o_h0_status, 2'b11);
    check("timeout_data", bus.o_h0_read_data, 32'h0);
    check("timeout_len", last_len, 3);

    // ready in the same cycle the counter would expire
    pend[0] = 1'b1; h_addr[0] = 16'h0024; h_wr[0] = 1'b0;
    drive_hosts();
    run_access(1'b1, 3, 32'h12345678, 1'b0, g);
    check("late_ready_status", bus.o_h0_status, 2'b00);
    check("late_ready_data", bus.o_h0_read_data, 32'h12345678);
    check("late_ready_len", last_len, 3);

    // h1 write to an unmapped address
    pend[1] = 1'b1; h_addr[1] = 16'h00FC; h_wr[1] = 1'b1; h_wd[1] = 32'hCAFEF00D;
    drive_hosts();
    run_access(1'b0, 1, 32'h5555AAAA, 1'b0, g);
    check("decode_err_status", bus.o_h1_status, 2'b10);
    check("decode_err_data", bus.o_h1_read_data, 32'h0);
    check("decode_err_len", last_len, 1);

    // both hosts persistently requesting alternate
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) if (!pend[h]) new_request(h);
      run_access(1'b1, 1, DW'($urandom), 1'b0, g);
      seq[i] = last_done;
    end
    for (int i = 0; i < 4; i++) check("alternate_grant", seq[i], want_seq[i]);

    // finish the leftover h0 request, then reset in the middle of an h1 access
    run_access(1'b1, 1, DW'($urandom), 1'b0, g);
    new_request(1);
    next_cycle();
    exp_req = 1'b1; exp_addr = h_addr[1]; exp_wr = h_wr[1]; exp_wd = h_wd[1];
    bus.i_select = 1'b1; bus.i_ready = 1'b0;
    #2;
    rst = 1'b1;
    exp_req = 1'b0;
    for (int h = 0; h < 2; h++) begin
      pend[h] = 1'b0; exp_rd[h] = '0; exp_st[h] = 2'b00;
    end
    prio = 0;
    drive_hosts();
    #1;
    check("reset_request_now", bus.o_request, 1'b0);
    check("reset_no_done", {bus.o_h0_done, bus.o_h1_done}, 2'b00);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bus.i_select = 1'b0;
    new_request(0);
    new_request(1);
    run_access(1'b1, 1, DW'($urandom), 1'b0, g);
    check("after_reset_grant", last_done, 0);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) next_cycle();
      end
      for (int h = 0; h < 2; h++) if (!pend[h] && $urandom_range(0, 1) == 1) new_request(h);
      if (!pend[0] && !pend[1]) new_request(int'($urandom_range(0, 1)));
      sel = ($urandom_range(0, 4) != 0);
      ra  = int'($urandom_range(0, TO + 1));
      run_access(sel, ra, DW'($urandom), 1'b1, g);
    end

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
